// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, 5..9 data bits LSB first,
// optional even/odd parity, one or two stop bits; gate pauses a frame.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_b,
  input  logic                 i_enable,
  input  logic                 i_select,
  output logic                 o_Tx_serial,
  output logic                 o_Tx_active,
  output logic                 o_ready,
  output logic                 o_data_recieved,
  output logic                 o_data_sent
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          PODD      = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [CW-1:0]        clk_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 parity;
  logic                 gate;
  logic                 bit_done;

  assign gate     = i_enable & i_select;
  assign bit_done = gate && (clk_cnt == CLK_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      clk_cnt         <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      parity          <= 1'b0;
      o_Tx_serial     <= 1'b1;
      o_Tx_active     <= 1'b0;
      o_ready         <= 1'b1;
      o_data_recieved <= 1'b0;
      o_data_sent     <= 1'b0;
    end else begin
      o_data_recieved <= 1'b0;
      o_data_sent     <= 1'b0;
      // bit timer only runs mid-frame and freezes with the gate
      if (state != IDLE && gate) begin
        if (clk_cnt == CLK_LAST) clk_cnt <= '0;
        else clk_cnt <= clk_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (i_Tx_DV) begin
            shreg           <= i_Tx_b;
            parity          <= ^i_Tx_b ^ PODD;
            clk_cnt         <= '0;
            bit_idx         <= '0;
            state           <= START;
            o_Tx_serial     <= 1'b0;
            o_Tx_active     <= 1'b1;
            o_ready         <= 1'b0;
            o_data_recieved <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state       <= DATA;
            o_Tx_serial <= shreg[0];
            shreg       <= shreg >> 1;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx != DATA_LAST) begin
              bit_idx     <= bit_idx + 1'b1;
              o_Tx_serial <= shreg[0];
              shreg       <= shreg >> 1;
            end else if (PARITY_EN != 0) begin
              state       <= PARITY;
              o_Tx_serial <= parity;
            end else begin
              state       <= STOP;
              bit_idx     <= '0;
              o_Tx_serial <= 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state       <= STOP;
            bit_idx     <= '0;
            o_Tx_serial <= 1'b1;
          end
        end
        STOP: begin
          // bit_idx doubles as the stop-bit counter
          if (bit_done) begin
            if (bit_idx != STOP_LAST) begin
              bit_idx <= bit_idx + 1'b1;
            end else begin
              state       <= IDLE;
              bit_idx     <= '0;
              o_Tx_active <= 1'b0;
              o_ready     <= 1'b1;
              o_data_sent <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five parameter sets run side by side,
// each with a driver, a queue of accepted payloads and a line monitor.
module tb_uart_tx_frame;

  localparam int NI = 5;

  logic clk;
  int   tests;
  int   fails;
  int   n_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tests  = 0;
    fails  = 0;
    n_done = 0;
  end

  for (genvar g = 0; g < NI; g++) begin : g_i
    localparam int CPB = (g == 3) ? 1 : (g == 4) ? 3 : 4;
    localparam int DB  = (g == 2) ? 5 : (g == 3) ? 9 :
                         (g == 4) ? 7 : 8;
    localparam int PE  = (g == 1 || g == 3 || g == 4) ? 1 : 0;
    localparam int PO  = (g >= 3) ? 1 : 0;
    localparam int SB  = (g == 2 || g == 3) ? 2 : 1;
    localparam int NB  = 1 + DB + PE + SB;
    localparam int B5  = (DB > 5) ? 5 : DB - 1;

    logic          rst_n;
    logic          tx_dv;
    logic [DB-1:0] tx_b;
    logic          enable;
    logic          select;
    logic          serial;
    logic          active;
    logic          ready;
    logic          recv;
    logic          sent;

    logic [DB-1:0] expq [$];
    int            exp_bits [16];
    int            spur;
    bit            in_f;
    int            cyc;
    int            gcnt;
    int            bad;
    int            hs;
    int            ones;
    logic [DB-1:0] md;

    uart_tx_frame #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB),
      .PARITY_EN   (PE),
      .PARITY_ODD  (PO),
      .STOP_BITS   (SB)
    ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_Tx_DV        (tx_dv),
      .i_Tx_b         (tx_b),
      .i_enable       (enable),
      .i_select       (select),
      .o_Tx_serial    (serial),
      .o_Tx_active    (active),
      .o_ready        (ready),
      .o_data_recieved(recv),
      .o_data_sent    (sent)
    );

    // one clock of stimulus; inputs change just after the rising edge
    task automatic step(input bit dv, input logic [DB-1:0] d,
                        input bit en, input bit sel,
                        output bit rdy, output bit acc);
      tx_dv  = dv;
      tx_b   = d;
      enable = en;
      select = sel;
      @(negedge clk);
      rdy = ready;
      acc = dv && ready;
      if (acc) expq.push_back(d);
      @(posedge clk);
      #1;
    endtask

    // mode 0: gate high, 1: random gate, 2: select low 10 cycles in data bit 3
    task automatic run(input int nfr, input int mode, input bit hold,
                       input bit rnd, input logic [DB-1:0] d0);
      bit rdy, acc, pend, en, sel;
      int j, paused, lim;
      logic [DB-1:0] d;
      pend = 1'b0;
      acc  = 1'b0;
      for (int f = 0; f < nfr; f++) begin
        if (!pend) begin
          lim = 0;
          acc = 1'b0;
          d = rnd ? DB'($urandom) : d0;
          while (!acc && lim < 500) begin
            step(1'b1, d, 1'b1, 1'b1, rdy, acc);
            lim++;
          end
          if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept inst%0d got no acceptance, required one", g);
            return;
          end
        end
        j = 0;
        paused = 0;
        rdy = 1'b0;
        while (!rdy && j < 3000) begin
          j++;
          en  = 1'b1;
          sel = 1'b1;
          if (mode == 1) begin
            en  = ($urandom_range(0, 7) != 0);
            sel = ($urandom_range(0, 7) != 0);
          end else if (mode == 2) begin
            sel = !(j >= 4 * CPB + 1 && j <= 4 * CPB + 10);
          end
          step(hold && (f < nfr - 1), DB'($urandom), en, sel, rdy, acc);
          if (!rdy && !(en && sel)) paused++;
        end
        tests++;
        if (!rdy || (j - 1) != NB * CPB + paused) begin
          fails++;
          $display("FAIL frame_len inst%0d got %0d cycles, required %0d",
                   g, j - 1, NB * CPB + paused);
        end
        pend = acc;
      end
    endtask

    task automatic mid_reset();
      bit rdy, acc;
      int lim;
      logic [DB-1:0] d;
      d = DB'($urandom);
      d[B5] = 1'b0;
      acc = 1'b0;
      lim = 0;
      while (!acc && lim < 500) begin
        step(1'b1, d, 1'b1, 1'b1, rdy, acc);
        lim++;
      end
      for (int k = 0; k < (1 + B5) * CPB; k++)
        step(1'b0, DB'($urandom), 1'b1, 1'b1, rdy, acc);
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if ({serial, ready, active, recv, sent} !== 5'b11000) begin
        fails++;
        $display("FAIL async_reset inst%0d got %b, required 11000",
                 g, {serial, ready, active, recv, sent});
      end
      tx_dv = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
    endtask

    initial begin : drv
      rst_n  = 1'b1;
      tx_dv  = 1'b0;
      tx_b   = '0;
      enable = 1'b1;
      select = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if ({serial, ready, active, recv, sent} !== 5'b11000) begin
        fails++;
        $display("FAIL reset inst%0d got %b, required 11000",
                 g, {serial, ready, active, recv, sent});
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      run(1, 0, 1'b0, 1'b0, DB'(8'hA5));
      run(1, 0, 1'b0, 1'b0, DB'(1));
      run(1, 0, 1'b0, 1'b0, DB'(9'h1F));
      run(1, 0, 1'b0, 1'b0, '1);
      run(1, 0, 1'b0, 1'b0, '0);
      run(1, 2, 1'b0, 1'b0, DB'(8'hA5));
      run(12, 1, 1'b0, 1'b1, '0);
      run(5, 0, 1'b1, 1'b1, '0);
      run(4, 1, 1'b1, 1'b1, '0);
      mid_reset();
      run(2, 1, 1'b0, 1'b1, '0);
      @(negedge clk);
      tests++;
      if (expq.size() != 0) begin
        fails++;
        $display("FAIL unsent inst%0d got %0d frames left, required 0",
                 g, expq.size());
      end
      tests++;
      if (spur != 0) begin
        fails++;
        $display("FAIL spurious_sent inst%0d got %0d, required 0", g, spur);
      end
      n_done++;
    end

    initial begin : mon
      spur = 0;
      in_f = 1'b0;
      cyc  = 0;
      gcnt = 0;
      bad  = 0;
      hs   = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          in_f = 1'b0;
        end else begin
          if (!in_f && sent) spur++;
          if (!in_f && recv) begin
            if (expq.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL no_expected inst%0d got a frame, required none", g);
            end else begin
              md = expq.pop_front();
              ones = 0;
              exp_bits[0] = 0;
              for (int i = 0; i < DB; i++) begin
                exp_bits[1 + i] = int'(md[i]);
                ones += int'(md[i]);
              end
              if (PE != 0) exp_bits[1 + DB] = (ones % 2) ^ PO;
              for (int i = 1 + DB + PE; i < NB; i++) exp_bits[i] = 1;
              in_f = 1'b1;
              cyc  = 0;
              gcnt = 0;
              bad  = 0;
              hs   = 0;
            end
          end
          if (in_f) begin
            if (sent) begin
              tests++;
              if (bad != 0 || gcnt != NB * CPB) begin
                fails++;
                $display("FAIL frame_bits inst%0d data=%h bad=%0d gated=%0d, required 0 and %0d",
                         g, md, bad, gcnt, NB * CPB);
              end
              tests++;
              if (hs != 0) begin
                fails++;
                $display("FAIL frame_flags inst%0d got %0d bad cycles, required 0", g, hs);
              end
              tests++;
              if ({serial, ready, active} !== 3'b110) begin
                fails++;
                $display("FAIL end_state inst%0d got %b, required 110",
                         g, {serial, ready, active});
              end
              in_f = 1'b0;
            end else begin
              if (gcnt / CPB >= NB || int'(serial) != exp_bits[gcnt / CPB]) bad++;
              if (!active || ready || (recv && cyc > 0)) hs++;
              if (enable && select) gcnt++;
              cyc++;
            end
          end
        end
      end
    end
  end

  initial begin : top
    int c;
    c = 0;
    #2;
    while (n_done < NI && c < 60000) begin
      @(posedge clk);
      c++;
    end
    if (n_done < NI) begin
      tests++;
      fails++;
      $display("FAIL timeout got %0d done, required %0d", n_done, NI);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 serialiser in the UART block. It adds configurable data width, optional even/odd parity, one or two stop bits, and an asynchronous active-low reset. The enable/select gate now pauses a frame instead of aborting it. The block sits between the bus-side command logic, which drives valid/ready, and the serial line pin.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; integer ≥1
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
i_clk  in  1  rising-edge system clock
i_rst_n  in  1  asynchronous active-low reset
i_Tx_DV  in  1  data valid; a transfer is accepted when i_Tx_DV=1 and o_ready=1 at a rising edge
i_Tx_b  in  DATA_BITS  payload, sampled on acceptance
i_enable  in  1  line enable; gate = i_enable & i_select
i_select  in  1  channel select
o_Tx_serial  out  1  serial line, idles high
o_Tx_active  out  1  high from the first start-bit cycle through the last stop-bit cycle
o_ready  out  1  high only in IDLE
o_data_recieved  out  1  one-cycle pulse: payload accepted
o_data_sent  out  1  one-cycle pulse: frame complete

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; o_Tx_serial=1; o_ready=1; o_Tx_active=0; o_data_recieved=0; o_data_sent=0; counters=0; shift register=0.
- Reset asserted mid-frame: the line returns high immediately and the frame is lost; no o_data_sent pulse.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_Tx_serial=1, o_ready=1.
  - On acceptance at edge E: latch i_Tx_b; compute parity = ^i_Tx_b ^ PARITY_ODD.
  - At the same edge E: go to START, o_Tx_serial=0, o_Tx_active=1, o_ready=0, o_data_recieved=1 for exactly one cycle.
- Bit timing: each bit is held for CLKS_PER_BIT gated cycles. The bit counter has width max(1, clog2(CLKS_PER_BIT)) and counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances.
- DATA: bits go out LSB first. The bit index has width max(1, clog2(DATA_BITS)). After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
- PARITY: drive the latched parity bit for one bit time, then go to STOP.
- STOP:
  - Drive 1 for STOP_BITS bit times.
  - At the final edge: go to IDLE; o_Tx_active=0, o_ready=1, o_data_sent=1 for one cycle.
- Frame length with the gate held high: (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames: a new transfer is accepted no earlier than the first IDLE cycle, so the minimum inter-frame line-high gap is 1 clock beyond the stop bits.
- Gate low in START, DATA, PARITY or STOP:
  - Bit counter, bit index and state freeze; o_Tx_serial holds its value; o_Tx_active stays 1.
  - Transmission resumes when the gate returns high. Pausing never aborts a frame.
- Gate in IDLE: has no effect; acceptance does not require the gate.
- i_Tx_DV while o_ready=0: ignored; the payload is not latched and no pulse is produced.
- Changing i_Tx_b after acceptance has no effect on the frame in flight.
- DATA_BITS=9 with parity: a 12-bit frame is legal.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset, then CLKS_PER_BIT=4, 8N1, accept 0xA5 with the gate high → the line, per 4-cycle bit, reads 0,1,0,1,0,0,1,0,1,1. o_data_recieved pulses at the acceptance edge. o_data_sent pulses 40 cycles later. o_Tx_active is high for exactly 40 cycles.
2. PARITY_EN=1, PARITY_ODD=0, send 0xA5 → parity bit 0, frame 44 cycles. Rebuild with PARITY_ODD=1 → parity bit 1. Send 0x01 with even parity → parity bit 1.
3. STOP_BITS=2, DATA_BITS=5, send 0x1F → line reads 0,1,1,1,1,1,1,1; frame 32 cycles; o_ready stays 0 until the frame ends.
4. Drop i_select for 10 cycles during data bit 3 → the line holds bit 3 and the frame stretches to exactly 50 cycles. Payload integrity is preserved and there is no early o_data_sent.
5. Hold i_Tx_DV high continuously with changing i_Tx_b → only the values present at each IDLE acceptance are sent. Frames are separated by one extra idle-high cycle. Mid-frame data changes do not corrupt the frame.
6. Assert i_rst_n low during DATA bit 5 → o_Tx_serial=1, o_ready=1 and o_Tx_active=0 asynchronously, before the next edge. No o_data_sent pulse. A fresh frame after release is transmitted correctly.
